// File: rtl/lstm_pkg.sv
// Shared BiLSTM definitions: scheduler state codes and
// the per-timestep feature count used by input_memory.
package lstm_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int INPUTS_PER_TIMESTEP = 6;

endpackage

// File: rtl/input_mem_scheduler.sv
// Input memory sequencer: loads a sequence from a valid/ready
// stream, then streams 6 features per timestep to both cells.
// Ports: clk/rst (sync, active-high), start, in_* load stream,
// write_* memory port, timestamp_idx/read_enable_*/input_pointer
// read control, elem_valid/elem_last, cell_step_done, busy, done.
// Optional INPUT_SCHED_RELOAD_EN adds 'reload' (0 = skip LOAD).
module input_mem_scheduler
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH          = 16,
  parameter int ADDR_WIDTH          = 6,
  parameter int SEQ_LEN             = 10,
  parameter int INPUTS_PER_TIMESTEP = lstm_pkg::INPUTS_PER_TIMESTEP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef INPUT_SCHED_RELOAD_EN
  input  logic                  reload,
`endif
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [3:0]            timestamp_idx,
  output logic                  read_enable_fwd,
  output logic                  read_enable_bwd,
  output logic [ADDR_WIDTH-1:0] input_pointer,
  output logic                  elem_valid,
  output logic                  elem_last,
  input  logic                  cell_step_done,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LC_LAST =
    ADDR_WIDTH'(SEQ_LEN * INPUTS_PER_TIMESTEP - 1);
  localparam logic [2:0] P_LAST = 3'(INPUTS_PER_TIMESTEP - 1);
  localparam logic [3:0] T_LAST = 4'(SEQ_LEN - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] lc_q, lc_d;
  logic [2:0]            p_q, p_d;
  logic [3:0]            t_q, t_d;
  logic                  elem_valid_q, elem_valid_d;
  logic                  elem_last_q, elem_last_d;
  logic                  rd;

  assign rd = (state_q == S_STREAM);

  always_comb begin
    state_d      = state_q;
    lc_d         = lc_q;
    p_d          = p_q;
    t_d          = t_q;
    // Read data appears one cycle after the enable.
    elem_valid_d = rd;
    elem_last_d  = rd && (p_q == P_LAST);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_d = '0;
          p_d = '0;
`ifdef INPUT_SCHED_RELOAD_EN
          if (reload) begin
            state_d = S_LOAD;
            lc_d    = '0;
          end else begin
            state_d = S_STREAM;
          end
`else
          state_d = S_LOAD;
          lc_d    = '0;
`endif
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          lc_d = lc_q + 1'b1;
          if (lc_q == LC_LAST) begin
            state_d = S_STREAM;
            t_d     = '0;
            p_d     = '0;
          end
        end
      end
      S_STREAM: begin
        if (p_q == P_LAST) state_d = S_WAIT;
        else               p_d     = p_q + 1'b1;
      end
      S_WAIT: begin
        if (cell_step_done) begin
          if (t_q == T_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_STREAM;
            t_d     = t_q + 1'b1;
            p_d     = '0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lc_q         <= '0;
      p_q          <= '0;
      t_q          <= '0;
      elem_valid_q <= 1'b0;
      elem_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lc_q         <= lc_d;
      p_q          <= p_d;
      t_q          <= t_d;
      elem_valid_q <= elem_valid_d;
      elem_last_q  <= elem_last_d;
    end
  end

  assign in_ready        = (state_q == S_LOAD);
  assign write_enable    = in_ready && in_valid;
  assign write_address   = write_enable ? lc_q : '0;
  assign write_data      = write_enable ? in_data : '0;
  assign timestamp_idx   = t_q;
  assign read_enable_fwd = rd;
  assign read_enable_bwd = rd;
  assign input_pointer   = ADDR_WIDTH'(p_q);
  assign elem_valid      = elem_valid_q;
  assign elem_last       = elem_last_q;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_input_mem_scheduler.sv
// Scoreboard bench for input_mem_scheduler: write and read
// expectations are queued at stimulus time, popped on outputs.
module tb_input_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        cell_step_done = 1'b0;
`ifdef INPUT_SCHED_RELOAD_EN
  logic        reload = 1'b1;
`endif
  logic        in_ready, write_enable;
  logic [5:0]  write_address;
  logic [15:0] write_data;
  logic [3:0]  timestamp_idx;
  logic        read_enable_fwd, read_enable_bwd;
  logic [5:0]  input_pointer;
  logic        elem_valid, elem_last, busy, done;

  input_mem_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
`ifdef INPUT_SCHED_RELOAD_EN
    .reload         (reload),
`endif
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .write_enable   (write_enable),
    .write_address  (write_address),
    .write_data     (write_data),
    .timestamp_idx  (timestamp_idx),
    .read_enable_fwd(read_enable_fwd),
    .read_enable_bwd(read_enable_bwd),
    .input_pointer  (input_pointer),
    .elem_valid     (elem_valid),
    .elem_last      (elem_last),
    .cell_step_done (cell_step_done),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int elem_cnt = 0;
  int done_cnt = 0;

  logic [21:0] wr_q[$];
  logic [6:0]  rd_q[$];
  logic [4:0]  el_q[$];

  logic [39:0] outs;
  assign outs = {in_ready, write_enable, write_address, write_data,
                 timestamp_idx, read_enable_fwd, read_enable_bwd,
                 input_pointer, elem_valid, elem_last, busy, done};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (write_enable) begin
        if (wr_q.size() == 0) chk("wr_extra", write_enable, 0);
        else begin
          logic [21:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", write_address, e[21:16]);
          chk("wr_data", write_data, e[15:0]);
        end
      end
      if (read_enable_fwd) begin
        if (rd_q.size() == 0) chk("rd_extra", read_enable_fwd, 0);
        else begin
          logic [6:0] e;
          e = rd_q.pop_front();
          chk("rd_t", timestamp_idx, e[6:3]);
          chk("rd_p", input_pointer, e[2:0]);
          chk("rd_bwd", read_enable_bwd, 1);
        end
      end
      if (elem_valid) begin
        elem_cnt++;
        if (el_q.size() == 0) chk("el_extra", elem_valid, 0);
        else begin
          logic [4:0] e;
          e = el_q.pop_front();
          chk("el_last", elem_last, e[4]);
          chk("el_t", timestamp_idx, e[3:0]);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_reads();
    for (int t = 0; t < 10; t++)
      for (int p = 0; p < 6; p++) begin
        rd_q.push_back({4'(t), 3'(p)});
        el_q.push_back({(p == 5), 4'(t)});
      end
  endtask

  task automatic wait_rd(input int p, output bit ok);
    ok = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (read_enable_fwd && input_pointer == 6'(p)) ok = 1;
    end
    chk($sformatf("wait_rd_p%0d", p), ok, 1);
  endtask

  task automatic do_load(input int toggle, input int noise,
                         input int base, input int mul);
    int i = 0;
    int n = 0;
    int pushed = -1;
    while (i < 60 && n < 400) begin
      in_valid = toggle ? (n % 2 == 0) : 1'b1;
      in_data  = 16'(base + i * mul);
      start    = noise ? (n % 3 == 1) : 1'b0;
      if (in_valid && pushed != i) begin
        wr_q.push_back({6'(i), in_data});
        pushed = i;
      end
      @(negedge clk);
      if (in_valid && in_ready) i++;
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("load_cycles", n, toggle ? 119 : 60);
    @(negedge clk);
    chk("ready_after", in_ready, 0);
    chk("stream_go", read_enable_fwd, 1);
    chk("stream_p0", input_pointer, 0);
  endtask

  task automatic do_stream(input int noise, input int abort);
    bit ok;
    for (int s = 0; s < 10; s++) begin
      if (abort && s == 4) begin
        wait_rd(2, ok);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outs", outs, 0);
        rd_q.delete();
        el_q.delete();
        return;
      end
      if (noise) begin
        wait_rd(1, ok);
        @(posedge clk); #1;
        cell_step_done = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        cell_step_done = 1'b0;
        start = 1'b0;
      end
      wait_rd(5, ok);
      @(posedge clk);
      @(negedge clk);
      chk("wait_re", read_enable_fwd, 0);
      chk("wait_t", timestamp_idx, s);
      @(posedge clk);
      @(posedge clk); #1 cell_step_done = 1'b1;
      @(posedge clk); #1 cell_step_done = 1'b0;
      if (s == 9) begin
        @(negedge clk);
        chk("done_hi", done, 1);
        @(negedge clk);
        chk("done_lo", done, 0);
        chk("idle", busy, 0);
      end
    end
  endtask

  task automatic run_seq(input int toggle, input int noise,
                         input int base, input int mul,
                         input int abort);
    elem_cnt = 0;
    done_cnt = 0;
    push_reads();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    do_load(toggle, noise, base, mul);
    do_stream(noise, abort);
    if (!abort) begin
      chk("elem_cnt", elem_cnt, 60);
      chk("done_cnt", done_cnt, 1);
      chk("rd_left", rd_q.size(), 0);
      chk("el_left", el_q.size(), 0);
    end
    chk("wr_left", wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", outs, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_outs", outs, 0);
    // Stray stimulus in IDLE must not start anything.
    @(posedge clk); #1;
    in_valid = 1'b1;
    cell_step_done = 1'b1;
    @(negedge clk);
    chk("idle_ready", in_ready, 0);
    chk("idle_we", write_enable, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cell_step_done = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    run_seq(0, 0, 0, 1, 0);
    run_seq(1, 0, 1000, 3, 0);
    run_seq(0, 1, 16'h8000, 257, 0);
    run_seq(0, 0, 77, 5, 1);
    run_seq(0, 0, 16'hfff0, 11, 0);

`ifdef INPUT_SCHED_RELOAD_EN
    begin
      elem_cnt = 0;
      done_cnt = 0;
      push_reads();
      @(posedge clk); #1;
      start  = 1'b1;
      reload = 1'b0;
      @(negedge clk);
      chk("rl_we", write_enable, 0);
      chk("rl_idle_re", read_enable_fwd, 0);
      @(posedge clk); #1;
      start  = 1'b0;
      reload = 1'b1;
      @(negedge clk);
      chk("rl_re", read_enable_fwd, 1);
      chk("rl_t0", timestamp_idx, 0);
      chk("rl_p0", input_pointer, 0);
      chk("rl_we2", write_enable, 0);
      do_stream(0, 0);
      chk("rl_elem_cnt", elem_cnt, 60);
      chk("rl_done_cnt", done_cnt, 1);
    end
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/input_mem_scheduler.md
# input_mem_scheduler

Sequencer for the shared BiLSTM input memory. Accepts a full input sequence on a valid/ready stream and writes it into the input memory. Then, per timestep, drives the memory's timestamp index, read enables and element pointer so the forward and backward LSTM cells each receive the 6 input features of their timestep. It waits for the cells to finish a timestep before advancing, and signals completion after the last timestep.

## Interface
Parameters:
- DATA_WIDTH, 16, width of one input element (signed Q-format, passed through untouched)
- ADDR_WIDTH, 6, input memory address width
- SEQ_LEN, 10, timesteps per sequence (≤16, fits timestamp_idx)
- INPUTS_PER_TIMESTEP, 6, features per timestep

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- start  in  1  begin a sequence; sampled only in IDLE
- in_valid  in  1  load-stream element valid
- in_data  in  DATA_WIDTH  load-stream element (signed)
- in_ready  out  1  scheduler accepts in_data this cycle
- write_enable  out  1  input memory write strobe
- write_address  out  ADDR_WIDTH  input memory write address
- write_data  out  DATA_WIDTH  input memory write data
- timestamp_idx  out  4  current timestep t (memory computes fwd row t, bwd row SEQ_LEN-1-t)
- read_enable_fwd  out  1  fans out to all four forward gate read enables
- read_enable_bwd  out  1  fans out to all four backward gate read enables
- input_pointer  out  ADDR_WIDTH  feature index 0..5, shared by all eight read ports
- elem_valid  out  1  memory read data valid this cycle
- elem_last  out  1  with elem_valid: feature 5 of the timestep
- cell_step_done  in  1  both cells finished current timestep (single-cycle pulse)
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after last timestep

## Operation
- States: IDLE, LOAD, STREAM, WAIT_CELL, DONE.
- IDLE: start=1 → LOAD; load counter lc=0.
- LOAD:
  - in_ready=1.
  - On in_valid: write_enable=1, write_address=lc, write_data=in_data (combinational from the stream), lc++.
  - The accept with lc==SEQ_LEN*INPUTS_PER_TIMESTEP-1 → STREAM with t=0, p=0.
- STREAM:
  - read_enable_fwd=read_enable_bwd=1, input_pointer=p, timestamp_idx=t.
  - p increments every cycle, with no stall.
  - When p==INPUTS_PER_TIMESTEP-1 → WAIT_CELL.
- WAIT_CELL:
  - Read enables are 0. timestamp_idx holds t.
  - On cell_step_done: if t==SEQ_LEN-1 → DONE, else t++, p=0 → STREAM.
  - A cell_step_done pulse outside WAIT_CELL is ignored.
- DONE: done=1 for one cycle → IDLE. The next start is accepted the following cycle.
- start is ignored outside IDLE.
- in_valid is ignored outside LOAD, and in_ready=0 there.
- Counters are unsigned. lc is ADDR_WIDTH bits, p is 3 bits, t is 4 bits. No wrap occurs within legal parameters.

## Timing
- Reset values: in_ready=0, write_enable=0, write_address=0, write_data=0, timestamp_idx=0, read_enable_*=0, input_pointer=0, elem_valid=0, elem_last=0, busy=0, done=0. State=IDLE.
- Reset mid-operation aborts immediately. Memory contents are untouched, but a fresh start reloads the memory.
- Load accepts at most 1 element per cycle, so 60 accepts take ≥60 cycles.
- Read latency:
  - elem_valid is read_enable_fwd registered 1 cycle, aligned with registered memory output.
  - elem_last is (p==5 & read) registered 1 cycle.
- Per timestep: 6 STREAM cycles, then ≥1 WAIT_CELL cycle. Minimum 7 cycles per step if cell_step_done is asserted in the first WAIT_CELL cycle.
- timestamp_idx is stable for the whole STREAM burst plus the following elem_valid cycle.
- Sequence-end rule: elem_last of step SEQ_LEN-1 precedes done, because done requires cell_step_done.

## Configuration
- INPUT_SCHED_RELOAD_EN defined:
  - Adds input port reload (1 bit), sampled with start.
  - start & reload=1 → LOAD as normal.
  - start & reload=0 → STREAM directly with t=0, reusing memory contents.
- Undefined: no reload port. Every start goes through LOAD.

## Structure
- Shared package (lstm_pkg) holds the state enum localparams (IDLE=0 … DONE=4) and INPUTS_PER_TIMESTEP=6, shared with input_memory.
- Single flat module; no sub-module needed.
- The elem_valid/elem_last alignment register is kept inline.

## Test plan
- Reset then 60 elements with values 0..59, in_valid held high → 60 consecutive write_enable pulses with addresses 0..59. STREAM starts on the cycle after the 60th accept.
- Load with in_valid toggling every other cycle → exactly 60 writes with no duplicate or skipped addresses. in_ready=0 after the 60th accept.
- Stream with cell_step_done pulsed 3 cycles after entering WAIT_CELL:
  - input_pointer runs 0..5 for t=0..9.
  - elem_valid count is 60.
  - elem_last is high on every 6th elem_valid.
  - done pulses once, after the 10th cell_step_done.
- start pulses during LOAD/STREAM and cell_step_done pulses during STREAM → no effect; the address and pointer sequences are unchanged.
- rst asserted at t=4, p=2 → next cycle all outputs at reset values. A new start reloads from address 0.
- With INPUT_SCHED_RELOAD_EN, start with reload=0 after a completed run → no write_enable, and the first read is at t=0, p=0 one cycle later.
